// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: start/done handshake from the harness plus decode controls in,
// and PC / status out. The master side drives the controls; the fetch stage is the slave.
interface instruction_fetch_if #(
    parameter int PC_WIDTH   = 10,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    logic                  start;
    logic [PC_WIDTH-1:0]   startAddr;
    logic                  halt;
    logic                  branch;
    logic                  jump;
    logic                  relative;
    logic [DATA_WIDTH-1:0] destBranchJump;
    logic                  compareFlag;
    logic [PC_WIDTH-1:0]   pc;
    logic                  running;
    logic                  done;
    logic [CNT_WIDTH-1:0]  insnCount;

    modport master (
        output start, startAddr, halt, branch, jump, relative, destBranchJump, compareFlag,
        input  pc, running, done, insnCount
    );

    modport slave (
        input  start, startAddr, halt, branch, jump, relative, destBranchJump, compareFlag,
        output pc, running, done, insnCount
    );
endinterface

// File: rtl/instruction_fetch.sv
// Program counter and start/halt sequencer for the fetch stage, one instruction per cycle,
// with a saturating retired-instruction counter.
//
// state  | meaning
// IDLE   | after reset; waiting for start, pc/count hold
// RUN    | retiring one instruction per cycle, pc follows decode controls
// HALTED | HLT retired; done held high until start or reset
module instruction_fetch #(
    parameter int PC_WIDTH   = 10,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [PC_WIDTH-1:0]   abs_target;
    logic [PC_WIDTH-1:0]   rel_offset;
    logic [PC_WIDTH-1:0]   redirect_target;
    logic                  take_redirect;

    // Absolute targets are zero-extended, offsets sign-extended; both truncate if wider than pc.
    if (DATA_WIDTH >= PC_WIDTH) begin : g_trunc
        assign abs_target = bus.destBranchJump[PC_WIDTH-1:0];
        assign rel_offset = bus.destBranchJump[PC_WIDTH-1:0];
    end else begin : g_extend
        assign abs_target = {{(PC_WIDTH-DATA_WIDTH){1'b0}}, bus.destBranchJump};
        assign rel_offset = {{(PC_WIDTH-DATA_WIDTH){bus.destBranchJump[DATA_WIDTH-1]}},
                             bus.destBranchJump};
    end

    assign redirect_target = bus.relative ? (pc_q + rel_offset) : abs_target;
    assign take_redirect   = bus.jump || (bus.branch && bus.compareFlag);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, HALTED: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = bus.startAddr;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (!(&cnt_q)) cnt_d = cnt_q + CNT_WIDTH'(1);
                // HLT retires but leaves pc on itself so the harness can see where it stopped.
                if (bus.halt) begin
                    state_d = HALTED;
                end else if (take_redirect) begin
                    pc_d = redirect_target;
                end else begin
                    pc_d = pc_q + PC_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.pc        = pc_q;
    assign bus.insnCount = cnt_q;
    assign bus.running   = (state_q == RUN);
    assign bus.done      = (state_q == HALTED);
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed test of instruction_fetch against an arithmetic reference model,
// plus literal expectations at key points of each scenario.
module tb_instruction_fetch;
    localparam int PW = 10;
    localparam int DW = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   armed    = 1'b0;

    int   m_pc, m_cnt;
    bit   m_run, m_done;

    always #5 clk = ~clk;

    instruction_fetch_if #(.PC_WIDTH(PW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    instruction_fetch #(.PC_WIDTH(PW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what the stage must do this edge, in plain integer arithmetic.
    always @(posedge clk) begin
        int off;
        if (reset) begin
            m_pc = 0; m_cnt = 0; m_run = 0; m_done = 0;
        end else if (!m_run) begin
            if (bus.start) begin
                m_pc = int'(bus.startAddr); m_cnt = 0; m_run = 1; m_done = 0;
            end
        end else begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            off = int'($signed(bus.destBranchJump));
            if (bus.halt) begin
                m_run = 0; m_done = 1;
            end else if (bus.jump || (bus.branch && bus.compareFlag)) begin
                if (bus.relative) m_pc = (m_pc + off) & 1023;
                else              m_pc = int'(bus.destBranchJump);
            end else begin
                m_pc = (m_pc + 1) & 1023;
            end
        end
        armed = 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            check("model_pc", int'(bus.pc), m_pc);
            check("model_running", int'(bus.running), int'(m_run));
            check("model_done", int'(bus.done), int'(m_done));
            check("model_count", int'(bus.insnCount), m_cnt);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        bus.start = 0; bus.halt = 0; bus.branch = 0; bus.jump = 0;
        bus.relative = 0; bus.destBranchJump = '0; bus.compareFlag = 0;
    endtask

    task automatic do_start(input logic [PW-1:0] addr);
        clear_ctl();
        bus.start = 1; bus.startAddr = addr;
        cycle();
        bus.start = 0;
    endtask

    task automatic ctl(input bit h, input bit b, input bit j, input bit r,
                       input logic [DW-1:0] d, input bit cf);
        bus.halt = h; bus.branch = b; bus.jump = j; bus.relative = r;
        bus.destBranchJump = d; bus.compareFlag = cf;
        cycle();
        clear_ctl();
    endtask

    initial begin
        clear_ctl();
        bus.startAddr = '0;
        reset = 1;
        cycle(); cycle();
        reset = 0;
        check("reset_pc", int'(bus.pc), 0);
        check("reset_running", int'(bus.running), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_count", int'(bus.insnCount), 0);
        cycle();
        check("idle_hold_pc", int'(bus.pc), 0);

        // Straight-line program ending in HLT at 0x008
        do_start(10'h005);
        check("start_pc", int'(bus.pc), 'h005);
        check("start_running", int'(bus.running), 1);
        cycle(); check("seq_pc6", int'(bus.pc), 'h006);
        cycle(); check("seq_pc7", int'(bus.pc), 'h007);
        cycle(); check("seq_pc8", int'(bus.pc), 'h008);
        ctl(1, 0, 0, 0, 8'h00, 0);
        check("halt_pc", int'(bus.pc), 'h008);
        check("halt_done", int'(bus.done), 1);
        check("halt_running", int'(bus.running), 0);
        check("halt_count", int'(bus.insnCount), 4);
        cycle();
        check("halted_hold_done", int'(bus.done), 1);

        // Conditional branches, relative targets
        do_start(10'h010);
        ctl(0, 1, 0, 1, 8'hFE, 0);
        check("branch_not_taken", int'(bus.pc), 'h011);
        ctl(0, 0, 1, 1, 8'hFF, 0);
        check("rel_jump_back", int'(bus.pc), 'h010);
        ctl(0, 1, 0, 1, 8'hFE, 1);
        check("branch_taken", int'(bus.pc), 'h00E);
        bus.start = 1; bus.startAddr = 10'h200;
        cycle();
        bus.start = 0;
        check("start_in_run_ignored", int'(bus.pc), 'h00F);
        ctl(1, 1, 1, 1, 8'h40, 1);
        check("halt_priority_pc", int'(bus.pc), 'h00F);
        check("halt_priority_done", int'(bus.done), 1);

        // Absolute jump, relative wrap, jump over branch, sequential wrap
        do_start(10'h3F0);
        ctl(0, 0, 1, 0, 8'hA5, 0);
        check("abs_jump", int'(bus.pc), 'h0A5);
        ctl(1, 0, 0, 0, 8'h00, 0);
        do_start(10'h3F0);
        ctl(0, 0, 1, 1, 8'h20, 0);
        check("rel_jump_wrap", int'(bus.pc), 'h010);
        ctl(0, 1, 1, 0, 8'h33, 0);
        check("jump_beats_branch", int'(bus.pc), 'h033);
        ctl(1, 0, 0, 0, 8'h00, 0);
        do_start(10'h3FF);
        cycle();
        check("seq_wrap", int'(bus.pc), 'h000);
        ctl(0, 0, 1, 1, 8'hFE, 0);
        check("neg_offset_wrap", int'(bus.pc), 'h3FE);

        // Reset aborts a running program
        ctl(1, 0, 0, 0, 8'h00, 0);
        do_start(10'h123);
        reset = 1;
        cycle();
        reset = 0;
        check("abort_pc", int'(bus.pc), 0);
        check("abort_running", int'(bus.running), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_count", int'(bus.insnCount), 0);
        do_start(10'h050);
        check("restart_pc", int'(bus.pc), 'h050);
        check("restart_running", int'(bus.running), 1);

        // Self-loop long enough to saturate the counter
        bus.jump = 1; bus.relative = 1; bus.destBranchJump = 8'h00;
        for (int i = 0; i < 70000; i++) cycle();
        clear_ctl();
        check("selfloop_pc", int'(bus.pc), 'h050);
        check("count_saturated", int'(bus.insnCount), 'hFFFF);
        ctl(1, 0, 0, 0, 8'h00, 0);
        check("saturated_after_halt", int'(bus.insnCount), 'hFFFF);
        check("final_done", int'(bus.done), 1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
